sim_run_ctrl: RTL and testbench

//  Parametrised run controller for simulation and FPGA bring-up of riscv_top.

---
 rtl/sim_run_ctrl_pkg.sv | 21 ++
 rtl/sim_run_ctrl_rst_stagger_chain.sv | 63 ++++++
 rtl/sim_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_sim_run_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// Shared definitions for the simulation run controller: FSM encoding and a
// helper that sizes down-counters.
package sim_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } run_state_e;

    // Number of bits needed to hold the value n (at least 1).
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sim_run_ctrl_rst_stagger_chain.sv
// Release sequencer: on i_start, drops per-domain resets one by one, STAGGER
// cycles apart, and flags the edge that releases the last domain.
module rst_stagger_chain
    import sim_run_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int STAGGER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic [NUM_CH-1:0] o_rst_out,
    output logic              o_last_released
);

    localparam bit ALL_AT_ONCE = (NUM_CH == 1) || (STAGGER == 0);
    localparam int IDX_W       = cnt_w(NUM_CH);
    localparam int TICK_W      = cnt_w(STAGGER);
    localparam int TICK_LOAD   = (STAGGER > 0) ? STAGGER - 1 : 0;

    logic [NUM_CH-1:0] r_rst;
    logic              r_active;
    logic [IDX_W-1:0]  r_idx;
    logic [TICK_W-1:0] r_tick;

    logic              w_step;
    logic              w_is_last;

    assign w_step    = r_active && (r_tick == '0);
    assign w_is_last = (r_idx == IDX_W'(NUM_CH - 1));

    assign o_last_released = (i_start && ALL_AT_ONCE) || (w_step && w_is_last);
    assign o_rst_out       = r_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst    <= '1;
            r_active <= 1'b0;
            r_idx    <= '0;
            r_tick   <= '0;
        end else if (i_start) begin
            if (ALL_AT_ONCE) begin
                r_rst <= '0;
            end else begin
                r_rst    <= r_rst & ~NUM_CH'(1);
                r_active <= 1'b1;
                r_idx    <= IDX_W'(1);
                r_tick   <= TICK_W'(TICK_LOAD);
            end
        end else if (w_step) begin
            r_rst <= r_rst & ~(NUM_CH'(1) << r_idx);
            if (w_is_last) begin
                r_active <= 1'b0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_tick <= TICK_W'(TICK_LOAD);
            end
        end else if (r_active) begin
            r_tick <= r_tick - TICK_W'(1);
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: reset hold, staggered domain release, gated run with cycle
// budget, halt-triggered drain window and sticky done/timeout flags.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int RST_CYCLES   = 25,
    parameter int STAGGER      = 1,
    parameter int MAX_CYCLES   = 250,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_req,
    input  logic              pause,
    output logic [NUM_CH-1:0] rst_out,
    output logic              rdy_out,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output run_state_e        dbg_state
);

    localparam int DCNT_MAX   = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int DCNT_W     = cnt_w(DCNT_MAX);
    localparam int HOLD_LOAD  = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    run_state_e        r_state;
    run_state_e        w_next;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  w_cycle_cnt_nxt;
    logic              r_running;
    logic              r_done;
    logic              r_timeout;
    logic              w_running_nxt;
    logic              w_done_nxt;
    logic              w_timeout_nxt;

    logic              w_dcnt_zero;
    logic              w_start;
    logic              w_last_released;
    logic              w_tick;
    logic              w_budget_hit;

    assign w_dcnt_zero = (r_dcnt == '0);
    assign w_start     = (r_state == ST_HOLD) && w_dcnt_zero;
    // A halt on the same edge suppresses both the increment and the timeout.
    assign w_tick       = (r_state == ST_RUN) && !halt_req && !pause;
    assign w_budget_hit = (MAX_CYCLES != 0) && w_tick &&
                          (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));

    rst_stagger_chain #(
        .NUM_CH  (NUM_CH),
        .STAGGER (STAGGER)
    ) u_chain (
        .clk             (clk),
        .rst             (rst),
        .i_start         (w_start),
        .o_rst_out       (rst_out),
        .o_last_released (w_last_released)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_dcnt      <= DCNT_W'(HOLD_LOAD);
            r_cycle_cnt <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_dcnt      <= w_dcnt_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_running   <= w_running_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_start) begin
                    w_next = w_last_released ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_last_released) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end else if (w_budget_hit) begin
                    w_next = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (w_dcnt_zero) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_HOLD;
        endcase
    end

    // The down-counter is shared by the hold window and the drain window.
    always_comb begin
        w_dcnt_nxt      = r_dcnt;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_running_nxt   = (w_next == ST_RUN) || (w_next == ST_DRAIN);
        w_done_nxt      = (w_next == ST_DONE);
        w_timeout_nxt   = r_timeout || w_budget_hit;
        case (r_state)
            ST_HOLD, ST_DRAIN: begin
                if (!w_dcnt_zero) begin
                    w_dcnt_nxt = r_dcnt - DCNT_W'(1);
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_dcnt_nxt = DCNT_W'(DRAIN_LOAD);
                end
            end
            default: w_dcnt_nxt = r_dcnt;
        endcase
        if (w_tick && !(&r_cycle_cnt)) begin
            w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
        end
    end

    assign running   = r_running;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign cycle_cnt = r_cycle_cnt;
    assign rdy_out   = r_running && !pause;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomised bench for sim_run_ctrl: default-parameter DUT plus a 4-channel
// zero-stagger DUT, both driven by the same stimulus and checked every edge.
module tb_sim_run_ctrl;
    import sim_run_ctrl_pkg::*;

    localparam int RST  = 25;
    localparam int STAG = 1;
    localparam int NCH  = 2;
    localparam int MAXC = 250;
    localparam int DRN  = 4;
    localparam int CW   = 32;
    localparam int RUN_START = RST + (NCH - 1) * STAG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           halt_req = 1'b0;
    logic           pause = 1'b0;
    logic [NCH-1:0] rst_out;
    logic           rdy_out, running, done, timeout;
    logic [CW-1:0]  cycle_cnt;
    run_state_e     dbg_state;

    logic [3:0]     rst_out4;
    logic           rdy_out4, running4, done4, timeout4;
    logic [CW-1:0]  cycle_cnt4;
    run_state_e     dbg_state4;

    sim_run_ctrl dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .pause(pause),
        .rst_out(rst_out), .rdy_out(rdy_out), .running(running), .done(done),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
    );

    sim_run_ctrl #(.NUM_CH(4), .STAGGER(0)) dut4 (
        .clk(clk), .rst(rst), .halt_req(halt_req), .pause(pause),
        .rst_out(rst_out4), .rdy_out(rdy_out4), .running(running4), .done(done4),
        .timeout(timeout4), .cycle_cnt(cycle_cnt4), .dbg_state(dbg_state4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: edges since reset release, run-cycle count, halt edge.
    int     m_e = 0;
    longint m_cnt = 0;
    int     m_halt_edge = -1;
    bit     m_to = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, m_e);
        end
    endtask

    function automatic bit m_done();
        return m_to || (m_halt_edge >= 0 && m_e >= m_halt_edge + DRN);
    endfunction

    function automatic bit m_running();
        return (m_e >= RUN_START) && !m_done();
    endfunction

    function automatic bit m_in_run();
        return (m_e >= RUN_START) && (m_halt_edge < 0) && !m_to;
    endfunction

    task automatic model_edge(input bit r, input bit h, input bit p);
        bit run_before;
        if (r) begin
            m_e = 0; m_cnt = 0; m_halt_edge = -1; m_to = 0;
        end else begin
            run_before = m_in_run();
            m_e++;
            if (run_before) begin
                if (h) begin
                    m_halt_edge = m_e;
                end else if (!p) begin
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (MAXC != 0 && m_cnt == MAXC) m_to = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit h, input bit p);
        logic [NCH-1:0] exp_rst;
        @(negedge clk);
        rst = r; halt_req = h; pause = p;
        @(posedge clk);
        model_edge(r, h, p);
        #1;
        for (int k = 0; k < NCH; k++) exp_rst[k] = !(m_e >= RST + k * STAG);
        chk("rst_out",   64'(rst_out),   64'(exp_rst));
        chk("running",   64'(running),   64'(m_running()));
        chk("done",      64'(done),      64'(m_done()));
        chk("timeout",   64'(timeout),   64'(m_to));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
        chk("rdy_out",   64'(rdy_out),   64'(m_running() && !p));
        chk("rst_out4",  64'(rst_out4),  (m_e >= RST) ? 64'h0 : 64'hF);
    endtask

    initial begin
        int mode, nrst, tail, p_left, halt_at;
        bit h, p, r, pause_used, rst_used;
        for (int run = 0; run < 9; run++) begin
            mode = (run < 6) ? run : 6;
            nrst = (mode == 0) ? 3 : $urandom_range(1, 3);
            for (int i = 0; i < nrst; i++) step(1'b1, 1'b0, 1'b0);
            tail = 0; p_left = 0; pause_used = 0; rst_used = 0;
            halt_at = $urandom_range(20, 200);
            for (int cyc = 0; cyc < 700 && tail < 3; cyc++) begin
                h = 0; p = 0; r = 0;
                if (m_e < RUN_START && mode >= 4) begin
                    // activity before RUN must have no effect
                    h = ($urandom_range(0, 3) == 0);
                    p = ($urandom_range(0, 3) == 0);
                end else if (m_in_run()) begin
                    case (mode)
                        1: h = (m_cnt == 100);
                        2: begin
                            if (m_cnt == 50 && !pause_used) begin
                                p_left = 10; pause_used = 1;
                            end
                        end
                        3: h = (m_cnt == MAXC - 1);
                        4, 5: h = (m_cnt == halt_at);
                        default: begin
                            h = ($urandom_range(0, 149) == 0);
                            if (p_left == 0 && $urandom_range(0, 19) == 0)
                                p_left = $urandom_range(1, 8);
                        end
                    endcase
                end
                if (p_left > 0) begin
                    p = 1; p_left--;
                end
                if (mode == 5 && !rst_used && m_halt_edge >= 0 && m_e == m_halt_edge + 2) begin
                    r = 1; rst_used = 1; h = 0;
                end else if (!m_in_run() && m_e >= RUN_START) begin
                    // halt during drain/done is ignored
                    h = ($urandom_range(0, 1) == 0);
                    p = ($urandom_range(0, 1) == 0);
                end
                step(r, h, p);
                if (m_done()) tail++;
            end
            if (tail == 0) begin
                n_vec++; n_err++;
                $display("FAIL run_end: run %0d never reached done (got 0 expected 1)", run);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
